// File: rtl/sync_ram_pkg.sv
// ---------------------------------------------------------------------------
// sync_ram_pkg
// Shared definitions for the small single-clock scratch RAM and its
// valid-bit tracker.
//   DEFAULT_DATA_WIDTH : default word width in bits
//   DEFAULT_ADDR_WIDTH : default address width in bits
//   DEFAULT_DEPTH      : number of words for the default address width
//   data_t / addr_t    : word and address types at the default sizes
//   depth_of()         : number of words addressed by an address width
// ---------------------------------------------------------------------------
package sync_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 6;

    // Full decode: every address pattern maps to a real word.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEFAULT_DEPTH = depth_of(DEFAULT_ADDR_WIDTH);

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/sync_ram_valid_tracker.sv
// ---------------------------------------------------------------------------
// sync_ram_valid_tracker
// One valid bit per RAM word. The storage array is never reset, so this
// vector is what makes the memory appear cleared after reset: a word only
// reads back its stored value once it has been written since the last reset.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears every valid bit
//   we         : write enable, marks write_addr valid on the clock edge
//   write_addr : word being written
//   read_addr  : word being looked up
//   read_valid : combinational valid bit of read_addr (pre-edge value)
// ---------------------------------------------------------------------------
module sync_ram_valid_tracker
    import sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_valid
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DEPTH-1:0] valid_bits;

    // A write arriving on the same edge that reset asserts is lost, because
    // the asynchronous clear takes priority over the clocked update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
        end else if (we) begin
            valid_bits[write_addr] <= 1'b1;
        end
    end

    // Looked up before the edge, so a same-address write does not make the
    // entry visible until the following edge.
    assign read_valid = valid_bits[read_addr];

endmodule

// File: rtl/sync_ram_sp_64x8.sv
// ---------------------------------------------------------------------------
// sync_ram_sp_64x8
// Simple dual-port synchronous RAM (one write port, one read port, one
// clock). Read data is registered with one cycle of latency and read-first
// behaviour on a same-address collision. Words that have not been written
// since reset read as zero.
// Ports:
//   clk        : rising-edge clock for both ports
//   rst_n      : asynchronous active-low reset; clears q and all valid bits
//   data       : write data
//   write_addr : write address
//   we         : write enable, active high
//   read_addr  : read address, sampled on every rising edge
//   q          : registered read data
// ---------------------------------------------------------------------------
module sync_ram_sp_64x8
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  read_valid;

    sync_ram_valid_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_valid_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .write_addr (write_addr),
        .read_addr  (read_addr),
        .read_valid (read_valid)
    );

    // Storage has no reset so it can map onto plain RAM; the valid vector
    // hides stale contents instead. Writes are gated off while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[write_addr] <= data;
        end
    end

    // Reading the array before this edge's write lands gives read-first
    // ordering. The valid mux keeps never-written (possibly X) words off q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= read_valid ? mem[read_addr] : '0;
        end
    end

endmodule

// File: tb/tb_sync_ram_sp_64x8.sv
// ---------------------------------------------------------------------------
// tb_sync_ram_sp_64x8
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic with occasional asynchronous resets, all checked every
// cycle against an array-based memory model.
// ---------------------------------------------------------------------------
module tb_sync_ram_sp_64x8;
    import sync_ram_pkg::*;

    logic  clk;
    logic  rst_n;
    data_t data;
    addr_t write_addr;
    logic  we;
    addr_t read_addr;
    data_t q;

    int    check_count = 0;
    int    fail_count  = 0;
    bit    check_en    = 1'b0;

    // Behavioural model: a plain array plus a "written since reset" flag.
    data_t model_mem   [DEFAULT_DEPTH];
    bit    model_valid [DEFAULT_DEPTH];
    data_t exp_q;

    sync_ram_sp_64x8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .write_addr (write_addr),
        .we         (we),
        .read_addr  (read_addr),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update: the read sees the memory as it was before this edge,
    // then the write (if any) is applied. Reset wipes all validity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEFAULT_DEPTH; i++) model_valid[i] = 1'b0;
            exp_q = '0;
        end else begin
            exp_q = model_valid[read_addr] ? model_mem[read_addr] : '0;
            if (we) begin
                model_mem[write_addr]   = data;
                model_valid[write_addr] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input data_t expected);
        check_count++;
        if ($isunknown(q) || q !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: q=%h expected %h at %0t", name, q, expected, $time);
        end
    endtask

    // Drive one access, then return at the following falling edge so q
    // reflects exactly that access.
    task automatic applyStimulus(input logic w, input addr_t wa, input data_t d,
                                 input addr_t ra);
        we         = w;
        write_addr = wa;
        data       = d;
        read_addr  = ra;
        @(negedge clk);
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) checkOutput("model", exp_q);
    end

    initial begin
        exp_q = '0;
        for (int i = 0; i < DEFAULT_DEPTH; i++) begin
            model_valid[i] = 1'b0;
            model_mem[i]   = '0;
        end
        rst_n      = 1'b1;
        we         = 1'b0;
        data       = '0;
        write_addr = '0;
        read_addr  = '0;

        // Reset pulse and read-after-reset.
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_q", 8'h00);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd0);
        checkOutput("read_after_reset_1", 8'h00);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd0);
        checkOutput("read_after_reset_2", 8'h00);

        // Basic write/read.
        applyStimulus(1'b1, 6'd0, 8'h56, 6'd0);
        checkOutput("rdw_invalid_entry", 8'h00);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd0);
        checkOutput("basic_read", 8'h56);

        // Overwrite: last write wins.
        applyStimulus(1'b1, 6'd0, 8'h56, 6'd1);
        applyStimulus(1'b1, 6'd0, 8'h78, 6'd1);
        checkOutput("unwritten_addr1", 8'h00);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd0);
        checkOutput("overwrite", 8'h78);

        // Read-during-write on the same address is read-first.
        applyStimulus(1'b1, 6'd5, 8'h11, 6'd0);
        applyStimulus(1'b1, 6'd5, 8'h22, 6'd5);
        checkOutput("rdw_old_data", 8'h11);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd5);
        checkOutput("rdw_new_data", 8'h22);

        // Independent ports and top of the address range.
        applyStimulus(1'b1, 6'd63, 8'hA5, 6'd0);
        applyStimulus(1'b1, 6'd1,  8'h3C, 6'd0);
        applyStimulus(1'b1, 6'd2,  8'h9E, 6'd63);
        checkOutput("read_top_addr", 8'hA5);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd1);
        checkOutput("read_addr1", 8'h3C);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd2);
        checkOutput("read_addr2", 8'h9E);

        // Asynchronous reset between edges; writes during reset are ignored.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_q", 8'h00);
        applyStimulus(1'b1, 6'd7, 8'hEE, 6'd63);
        checkOutput("q_held_in_reset", 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd63);
        checkOutput("valid_cleared", 8'h00);
        applyStimulus(1'b0, 6'd0, 8'h00, 6'd7);
        checkOutput("write_in_reset_dropped", 8'h00);

        // Randomized traffic; narrow address windows force collisions.
        for (int n = 0; n < 3000; n++) begin
            addr_t wa, ra;
            if ($urandom_range(0, 3) == 0) begin
                wa = addr_t'($urandom_range(0, 3));
                ra = addr_t'($urandom_range(0, 3));
            end else begin
                wa = addr_t'($urandom_range(0, DEFAULT_DEPTH - 1));
                ra = addr_t'($urandom_range(0, DEFAULT_DEPTH - 1));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("rand_async_reset", 8'h00);
                applyStimulus(1'b1, wa, data_t'($urandom), ra);
                rst_n = 1'b1;
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), wa, data_t'($urandom), ra);
            end
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
